// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read mux among NUM_REQ requesters.
// Grant, select, capture, then return the data with a one-hot valid two cycles after the request.
module regfile_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         mux_sel,
  input  logic [DATA_W-1:0]         mux_data,
  output logic [DATA_W-1:0]         rd_data,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   ptr, ptr_next;
  logic [PTR_W-1:0]   owner, owner_next;
  logic [PTR_W-1:0]   winner, idx;
  logic               found;
  logic [31:0]        pos;
  logic [NUM_REQ-1:0] gnt_next, rd_valid_next;
  logic [ADDR_W-1:0]  mux_sel_next;
  logic [DATA_W-1:0]  rd_data_next;

  // First active request at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    pos    = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = 32'(ptr) + 32'(k);
      if (pos >= 32'(NUM_REQ)) pos = pos - 32'(NUM_REQ);
      idx = PTR_W'(pos);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    owner_next    = owner;
    gnt_next      = '0;
    rd_valid_next = '0;
    mux_sel_next  = mux_sel;
    rd_data_next  = rd_data;
    case (state)
      IDLE: begin
        if (found) begin
          mux_sel_next = req_addr[winner*ADDR_W +: ADDR_W];
          gnt_next     = ONE << winner;
          owner_next   = winner;
          state_next   = CAPTURE;
        end
      end
      CAPTURE: begin
        // The granted requester drops to lowest priority for the next round.
        rd_data_next  = mux_data;
        rd_valid_next = ONE << owner;
        ptr_next      = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      gnt      <= '0;
      rd_valid <= '0;
      mux_sel  <= '0;
      rd_data  <= '0;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      owner    <= owner_next;
      gnt      <= gnt_next;
      rd_valid <= rd_valid_next;
      mux_sel  <= mux_sel_next;
      rd_data  <= rd_data_next;
    end
  end

  assign busy = (state == CAPTURE);

endmodule
